// File: rtl/oam_scan_pkg.sv
// Shared types and constants for the mode-2 OAM scan engine and its consumers.
//   ENTRY_W / *_LSB : packed sprite queue entry layout (MSB first: idx, y, x, tile, flags, row)
//   oam_entry_t     : one queue entry
//   scan_state_t    : scan FSM states
//   OAM_*_OFS       : byte offsets within a 4-byte OAM entry
//   SPRITE_Y_BIAS   : OAM Y is stored with a +16 bias relative to LY
package oam_scan_pkg;

   localparam int unsigned ENTRY_W         = 42;
   localparam int unsigned ENTRY_ROW_LSB   = 0;
   localparam int unsigned ENTRY_FLAGS_LSB = 4;
   localparam int unsigned ENTRY_TILE_LSB  = 12;
   localparam int unsigned ENTRY_X_LSB     = 20;
   localparam int unsigned ENTRY_Y_LSB     = 28;
   localparam int unsigned ENTRY_IDX_LSB   = 36;

   localparam logic [1:0] OAM_Y_OFS     = 2'd0;
   localparam logic [1:0] OAM_X_OFS     = 2'd1;
   localparam logic [1:0] OAM_TILE_OFS  = 2'd2;
   localparam logic [1:0] OAM_FLAGS_OFS = 2'd3;

   localparam int unsigned SPRITE_Y_BIAS = 16;

   typedef struct packed {
      logic [5:0] obj_idx;
      logic [7:0] y;
      logic [7:0] x;
      logic [7:0] tile;
      logic [7:0] flags;
      logic [3:0] row;
   } oam_entry_t;

   typedef enum logic [2:0] {
      StIdle,
      StRdY,
      StRdX,
      StRdTile,
      StRdFlags,
      StDone
   } scan_state_t;

endpackage

// File: rtl/oam_line_hit.sv
// Combinational sprite/line intersection test.
//   y_i    : OAM Y byte (biased by SPRITE_Y_BIAS)
//   ly_i   : current scanline
//   tall_i : 1 = 8x16 sprites, 0 = 8x8
//   hit_o  : sprite covers this line
//   row_o  : row within the sprite (valid when hit_o)
module oam_line_hit
   import oam_scan_pkg::*;
(
   input  logic [7:0] y_i,
   input  logic [7:0] ly_i,
   input  logic       tall_i,
   output logic       hit_o,
   output logic [3:0] row_o
);

   logic [8:0] t;
   logic [8:0] diff;

   // 9-bit so LY+16 never wraps and y > t shows up as a failed compare, not a huge diff.
   assign t     = {1'b0, ly_i} + 9'(SPRITE_Y_BIAS);
   assign diff  = t - {1'b0, y_i};
   assign hit_o = (t >= {1'b0, y_i}) && (diff < (tall_i ? 9'd16 : 9'd8));
   assign row_o = diff[3:0];

endmodule

// File: rtl/oam_scan_unit.sv
// Mode-2 OAM search: scans NUM_OBJS entries against a latched LY and sprite height and
// collects up to MAX_PER_LINE visible sprites, in OAM order, into a registered queue.
//   clk, rst          : clock, asynchronous active-high reset
//   start, abort      : begin scan (idle only) / terminate scan (busy only)
//   LCDC, LY          : bit1 OBJ enable, bit2 8x16; both sampled on start
//   oam_a, oam_rd     : OAM read address and one-cycle strobe per byte
//   oam_dout          : read data, valid RD_LATENCY cycles after the strobe
//   busy, done        : scan in progress / one-cycle completion pulse
//   sprite_count/valid/queue : accepted sprites for the mode-3 fetcher
module oam_scan_unit
   import oam_scan_pkg::*;
#(
   parameter logic [15:0] OAM_BASE     = 16'hFE00,
   parameter int unsigned NUM_OBJS     = 40,
   parameter int unsigned MAX_PER_LINE = 10,
   parameter int unsigned RD_LATENCY   = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    abort,
   input  logic [7:0]              LCDC,
   input  logic [7:0]              LY,
   output logic [15:0]             oam_a,
   output logic                    oam_rd,
   input  logic [7:0]              oam_dout,
   output logic                    busy,
   output logic                    done,
   output logic [4:0]              sprite_count,
   output logic [MAX_PER_LINE-1:0] sprite_valid,
   output oam_entry_t              sprite_queue [MAX_PER_LINE]
);

   scan_state_t state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [5:0]  obj_q, obj_d;
   logic [7:0]  ly_q, y_q, x_q, tile_q;
   logic        tall_q;
   logic [3:0]  row_q;
   logic [4:0]  count_q;
   logic [MAX_PER_LINE-1:0] valid_q;
   oam_entry_t  queue_q [MAX_PER_LINE];

   logic       start_scan, lat_y, lat_x, lat_tile, store;
   logic       rd_state, sample, last_obj, full_next;
   logic       line_hit;
   logic [3:0] line_row;
   logic [1:0] byte_ofs;
   oam_entry_t new_entry;
   logic       unused_lcdc;

   assign unused_lcdc = ^{LCDC[7:3], LCDC[0]};

   oam_line_hit u_line_hit (
      .y_i    (oam_dout),
      .ly_i   (ly_q),
      .tall_i (tall_q),
      .hit_o  (line_hit),
      .row_o  (line_row)
   );

   assign rd_state  = (state_q == StRdY) || (state_q == StRdX) ||
                      (state_q == StRdTile) || (state_q == StRdFlags);
   // Counter 0 issues the strobe; data is taken on the last wait cycle.
   assign sample    = (cnt_q == 2'(RD_LATENCY));
   assign last_obj  = (obj_q == 6'(NUM_OBJS - 1));
   assign full_next = ((count_q + 5'd1) == 5'(MAX_PER_LINE));

   always_comb begin
      byte_ofs = OAM_Y_OFS;
      unique case (state_q)
         StRdX:     byte_ofs = OAM_X_OFS;
         StRdTile:  byte_ofs = OAM_TILE_OFS;
         StRdFlags: byte_ofs = OAM_FLAGS_OFS;
         default:   byte_ofs = OAM_Y_OFS;
      endcase
   end

   assign oam_rd = rd_state && (cnt_q == 2'd0);
   assign oam_a  = rd_state ? (OAM_BASE + {8'd0, obj_q, byte_ofs}) : 16'd0;
   assign busy   = rd_state;
   assign done   = (state_q == StDone);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      obj_d      = obj_q;
      start_scan = 1'b0;
      lat_y      = 1'b0;
      lat_x      = 1'b0;
      lat_tile   = 1'b0;
      store      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               start_scan = 1'b1;
               cnt_d      = 2'd0;
               obj_d      = 6'd0;
               state_d    = LCDC[1] ? StRdY : StDone;
            end
         end
         StRdY, StRdX, StRdTile, StRdFlags: begin
            if (abort) begin
               state_d = StIdle;
               cnt_d   = 2'd0;
            end else if (!sample) begin
               cnt_d = cnt_q + 2'd1;
            end else begin
               cnt_d = 2'd0;
               case (state_q)
                  StRdY: begin
                     if (line_hit) begin
                        lat_y   = 1'b1;
                        state_d = StRdX;
                     end else if (last_obj) begin
                        state_d = StDone;
                     end else begin
                        obj_d   = obj_q + 6'd1;
                        state_d = StRdY;
                     end
                  end
                  StRdX: begin
                     lat_x   = 1'b1;
                     state_d = StRdTile;
                  end
                  StRdTile: begin
                     lat_tile = 1'b1;
                     state_d  = StRdFlags;
                  end
                  default: begin
                     store = 1'b1;
                     if (full_next || last_obj) begin
                        state_d = StDone;
                     end else begin
                        obj_d   = obj_q + 6'd1;
                        state_d = StRdY;
                     end
                  end
               endcase
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      new_entry.obj_idx = obj_q;
      new_entry.y       = y_q;
      new_entry.x       = x_q;
      new_entry.tile    = tile_q;
      new_entry.flags   = oam_dout;
      new_entry.row     = row_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= 2'd0;
         obj_q   <= 6'd0;
         ly_q    <= 8'd0;
         tall_q  <= 1'b0;
         y_q     <= 8'd0;
         row_q   <= 4'd0;
         x_q     <= 8'd0;
         tile_q  <= 8'd0;
         count_q <= 5'd0;
         valid_q <= '0;
         for (int i = 0; i < MAX_PER_LINE; i++) queue_q[i] <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         obj_q   <= obj_d;
         if (start_scan) begin
            ly_q    <= LY;
            tall_q  <= LCDC[2];
            count_q <= 5'd0;
            valid_q <= '0;
            for (int i = 0; i < MAX_PER_LINE; i++) queue_q[i] <= '0;
         end
         if (lat_y) begin
            y_q   <= oam_dout;
            row_q <= line_row;
         end
         if (lat_x) x_q <= oam_dout;
         // 8x16 sprites always start on an even tile.
         if (lat_tile) tile_q <= tall_q ? {oam_dout[7:1], 1'b0} : oam_dout;
         if (store) begin
            count_q <= count_q + 5'd1;
            for (int i = 0; i < MAX_PER_LINE; i++) begin
               if (count_q == 5'(i)) begin
                  queue_q[i] <= new_entry;
                  valid_q[i] <= 1'b1;
               end
            end
         end
      end
   end

   assign sprite_count = count_q;
   assign sprite_valid = valid_q;
   assign sprite_queue = queue_q;

endmodule

// File: tb/tb_oam_scan_unit.sv
module tb_oam_scan_unit;
   import oam_scan_pkg::*;

   localparam int unsigned LAT = 1;
   localparam int unsigned NOBJ = 40;
   localparam int unsigned MAXQ = 10;

   logic clk = 1'b0;
   logic rst, start, abort;
   logic [7:0] LCDC, LY, oam_dout;
   logic [15:0] oam_a;
   logic oam_rd, busy, done;
   logic [4:0] sprite_count;
   logic [MAXQ-1:0] sprite_valid;
   oam_entry_t sprite_queue [MAXQ];

   oam_scan_unit #(
      .OAM_BASE     (16'hFE00),
      .NUM_OBJS     (NOBJ),
      .MAX_PER_LINE (MAXQ),
      .RD_LATENCY   (LAT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .abort        (abort),
      .LCDC         (LCDC),
      .LY           (LY),
      .oam_a        (oam_a),
      .oam_rd       (oam_rd),
      .oam_dout     (oam_dout),
      .busy         (busy),
      .done         (done),
      .sprite_count (sprite_count),
      .sprite_valid (sprite_valid),
      .sprite_queue (sprite_queue)
   );

   always #5 clk = ~clk;

   // OAM memory with exact RD_LATENCY timing; data is garbage outside the valid window.
   logic [7:0]  mem [160];
   logic [16:0] addr_hold;
   logic [16:0] pipe [LAT];
   int          oam_idx;
   logic [15:0] rd_log [$];

   always @(negedge clk) begin
      addr_hold <= {oam_rd, oam_a};
      if (oam_rd) rd_log.push_back(oam_a);
   end

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < LAT; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= addr_hold;
         for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end
   end

   always_comb begin
      oam_idx  = int'(pipe[LAT-1][15:0]) - 32'hFE00;
      oam_dout = (pipe[LAT-1][16] && oam_idx >= 0 && oam_idx < 160) ? mem[oam_idx] : 8'hEE;
   end

   int n_tests = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference model: straight walk over OAM following the scan rules.
   logic [15:0] exp_addrs [$];
   logic [41:0] exp_ents [$];
   int exp_done;

   task automatic model(input logic [7:0] ly, input logic [7:0] lcdc);
      int t, y, h;
      exp_addrs.delete();
      exp_ents.delete();
      if (lcdc[1]) begin
         h = lcdc[2] ? 16 : 8;
         t = int'(ly) + 16;
         for (int n = 0; n < NOBJ; n++) begin
            logic [5:0] idx;
            logic [7:0] tile;
            logic [3:0] row;
            y = int'(mem[4*n]);
            exp_addrs.push_back(16'(32'hFE00 + 4*n));
            if (t >= y && (t - y) < h) begin
               for (int k = 1; k < 4; k++) exp_addrs.push_back(16'(32'hFE00 + 4*n + k));
               idx  = 6'(n);
               tile = lcdc[2] ? (mem[4*n+2] & 8'hFE) : mem[4*n+2];
               row  = 4'(t - y);
               exp_ents.push_back({idx, mem[4*n], mem[4*n+1], tile, mem[4*n+3], row});
               if (exp_ents.size() == MAXQ) break;
            end
         end
      end
      exp_done = exp_addrs.size() * (LAT + 1) + 1;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 160; i++) mem[i] = 8'h00;
   endtask

   // Full scan compared against the model; poke issues an ignored start mid-scan.
   task automatic run_scan(input string tag, input logic [7:0] ly, input logic [7:0] lcdc,
                           input bit poke);
      int cyc;
      model(ly, lcdc);
      @(negedge clk);
      rd_log.delete();
      LY = ly;
      LCDC = lcdc;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (cyc < 3000) begin
         if (poke && cyc == 10) begin
            start = 1'b1;
            LY = ly + 8'd3;
         end
         if (cyc == 11) start = 1'b0;
         if (done) break;
         @(negedge clk);
         cyc++;
      end
      check($sformatf("%s done_cycle", tag), 64'(cyc), 64'(exp_done));
      check($sformatf("%s busy_at_done", tag), 64'(busy), 64'd0);
      check($sformatf("%s count", tag), 64'(sprite_count), 64'(exp_ents.size()));
      check($sformatf("%s valid", tag), 64'(sprite_valid),
            (64'd1 << exp_ents.size()) - 64'd1);
      for (int i = 0; i < MAXQ; i++)
         check($sformatf("%s entry%0d", tag, i), 64'(sprite_queue[i]),
               (i < exp_ents.size()) ? 64'(exp_ents[i]) : 64'd0);
      check($sformatf("%s nreads", tag), 64'(rd_log.size()), 64'(exp_addrs.size()));
      for (int i = 0; i < exp_addrs.size(); i++)
         check($sformatf("%s rd%0d", tag, i),
               (i < rd_log.size()) ? 64'(rd_log[i]) : 64'hDEAD, 64'(exp_addrs[i]));
      @(negedge clk);
      check($sformatf("%s done_pulse", tag), 64'(done), 64'd0);
   endtask

   typedef struct {
      logic [7:0] y;
      logic [7:0] ly;
      bit         tall;
      bit         hit;
      logic [3:0] row;
   } vec_t;

   vec_t vt [10];

   initial begin
      int hold_ok;
      rst = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      LY = 8'd0;
      LCDC = 8'd0;
      clear_mem();
      repeat (2) @(negedge clk);
      check("rst busy", 64'(busy), 64'd0);
      check("rst done", 64'(done), 64'd0);
      check("rst oam_a", 64'(oam_a), 64'd0);
      check("rst oam_rd", 64'(oam_rd), 64'd0);
      check("rst count", 64'(sprite_count), 64'd0);
      check("rst valid", 64'(sprite_valid), 64'd0);
      rst = 1'b0;

      // All-zero OAM: 40 Y reads, done at cycle 81, stray start ignored.
      run_scan("zeros", 8'd0, 8'h82, 1'b1);
      check("zeros done81", 64'(exp_done), 64'd81);

      // Single hit on obj 5.
      clear_mem();
      mem[20] = 8'd16; mem[21] = 8'd8; mem[22] = 8'h23; mem[23] = 8'h80;
      run_scan("obj5", 8'd0, 8'h82, 1'b0);
      check("obj5 entry_const", 64'(sprite_queue[0]),
            64'({6'd5, 8'd16, 8'd8, 8'h23, 8'h80, 4'd0}));

      // Queue fills on obj 9; nothing at or past FE28 is read.
      clear_mem();
      for (int n = 0; n < 12; n++) begin
         mem[4*n] = 8'd20; mem[4*n+1] = 8'(n); mem[4*n+2] = 8'(n + 1); mem[4*n+3] = 8'h10;
      end
      run_scan("full", 8'd7, 8'h82, 1'b0);
      check("full valid_const", 64'(sprite_valid), 64'h3FF);
      check("full last_read", (rd_log.size() > 0) ? 64'(rd_log[rd_log.size()-1]) : 64'd0,
            64'hFE27);

      // OBJ disabled.
      run_scan("objoff", 8'd7, 8'h80, 1'b0);
      check("objoff no_reads", 64'(rd_log.size()), 64'd0);

      // Y test table: single object 0 against hand-computed hit/row.
      vt[0] = '{8'd16,  8'd0,   1'b0, 1'b1, 4'd0};
      vt[1] = '{8'd16,  8'd7,   1'b0, 1'b1, 4'd7};
      vt[2] = '{8'd16,  8'd8,   1'b0, 1'b0, 4'd0};
      vt[3] = '{8'd16,  8'd15,  1'b1, 1'b1, 4'd15};
      vt[4] = '{8'd16,  8'd15,  1'b0, 1'b0, 4'd0};
      vt[5] = '{8'd0,   8'd0,   1'b1, 1'b0, 4'd0};
      vt[6] = '{8'd176, 8'd143, 1'b1, 1'b0, 4'd0};
      vt[7] = '{8'd159, 8'd143, 1'b0, 1'b1, 4'd0};
      vt[8] = '{8'd10,  8'd0,   1'b0, 1'b1, 4'd6};
      vt[9] = '{8'd20,  8'd3,   1'b0, 1'b0, 4'd0};
      for (int i = 0; i < 10; i++) begin
         clear_mem();
         mem[0] = vt[i].y; mem[1] = 8'h11; mem[2] = 8'h41; mem[3] = 8'h5A;
         run_scan($sformatf("vec%0d", i), vt[i].ly, vt[i].tall ? 8'h86 : 8'h82, 1'b0);
         check($sformatf("vec%0d hit", i), 64'(sprite_count), 64'(vt[i].hit));
         if (vt[i].hit) begin
            check($sformatf("vec%0d row", i), 64'(sprite_queue[0].row), 64'(vt[i].row));
            check($sformatf("vec%0d tile", i), 64'(sprite_queue[0].tile),
                  vt[i].tall ? 64'h40 : 64'h41);
         end
      end

      // Randomized scans against the model.
      for (int r = 0; r < 24; r++) begin
         logic [7:0] lcdc;
         for (int i = 0; i < 160; i++) mem[i] = 8'($urandom);
         for (int n = 0; n < NOBJ; n++) mem[4*n] = 8'($urandom_range(0, 60));
         lcdc = 8'($urandom) | 8'h02;
         if (r % 8 == 7) lcdc[1] = 1'b0;
         run_scan($sformatf("rnd%0d", r), 8'($urandom_range(0, 40)), lcdc, 1'b0);
      end

      // Abort during obj 3's tile read with objs 0..2 committed.
      clear_mem();
      for (int n = 0; n < 4; n++) begin
         mem[4*n] = 8'd16; mem[4*n+1] = 8'(8 * n); mem[4*n+2] = 8'h30; mem[4*n+3] = 8'h00;
      end
      @(negedge clk);
      rd_log.delete();
      LY = 8'd0; LCDC = 8'h82; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (28) @(negedge clk);
      check("abort in_tile_issue", 64'(oam_a), 64'hFE0E);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort busy", 64'(busy), 64'd0);
      check("abort done", 64'(done), 64'd0);
      check("abort count", 64'(sprite_count), 64'd3);
      check("abort valid", 64'(sprite_valid), 64'h007);
      check("abort entry3", 64'(sprite_queue[3]), 64'd0);
      check("abort nreads", 64'(rd_log.size()), 64'd15);
      hold_ok = 1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done || busy || oam_rd) hold_ok = 0;
      end
      check("abort quiet", 64'(hold_ok), 64'd1);

      // Reset in the middle of a scan, between clock edges.
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      check("rst_mid pre_count", 64'(sprite_count), 64'd2);
      #2 rst = 1'b1;
      #1;
      check("rst_mid busy", 64'(busy), 64'd0);
      check("rst_mid oam_rd", 64'(oam_rd), 64'd0);
      check("rst_mid oam_a", 64'(oam_a), 64'd0);
      check("rst_mid count", 64'(sprite_count), 64'd0);
      check("rst_mid valid", 64'(sprite_valid), 64'd0);
      check("rst_mid entry0", 64'(sprite_queue[0]), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Scan still works after the reset.
      run_scan("post_rst", 8'd0, 8'h82, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
